// File: rtl/midi_pkg.sv
// midi_pkg
// Shared types and constants for the MIDI byte-stream parser.
//   parser_state_t : parser FSM states
//   status constants : channel-voice bases (low nibble = channel) and
//                      system-common status bytes
//   midi_data_len()  : number of data bytes that follow a status byte
package midi_pkg;

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    WAIT_D1   = 2'd1,
    WAIT_D2   = 2'd2,
    SYSEX     = 2'd3
  } parser_state_t;

  // Channel-voice status bases; the low nibble carries the channel.
  localparam logic [7:0] NOTE_OFF    = 8'h80;
  localparam logic [7:0] NOTE_ON     = 8'h90;
  localparam logic [7:0] POLY_AT     = 8'hA0;
  localparam logic [7:0] CC          = 8'hB0;
  localparam logic [7:0] PROG        = 8'hC0;
  localparam logic [7:0] CH_AT       = 8'hD0;
  localparam logic [7:0] BEND        = 8'hE0;

  // System-common status bytes.
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] MTC         = 8'hF1;
  localparam logic [7:0] SPP         = 8'hF2;
  localparam logic [7:0] SONG_SEL    = 8'hF3;
  localparam logic [7:0] TUNE_REQ    = 8'hF6;
  localparam logic [7:0] SYSEX_END   = 8'hF7;

  // Data bytes expected after a status byte. Data bytes, real-time bytes,
  // SysEx framing and the undefined F4/F5 all report 0.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    if (status[7]) begin
      if (status[7:4] != 4'hF) begin
        case (status & 8'hF0)
          PROG, CH_AT: len = 2'd1;
          default:     len = 2'd2;
        endcase
      end else begin
        case (status)
          MTC, SONG_SEL: len = 2'd1;
          SPP:           len = 2'd2;
          default:       len = 2'd0;
        endcase
      end
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_status_decode.sv
// midi_status_decode
// Purely combinational classification of one received MIDI byte.
//   byte_in        : raw byte
//   is_status      : bit 7 set
//   is_realtime    : 0xF8..0xFF, may interleave anywhere
//   is_sysex_start : 0xF0
//   is_sysex_end   : 0xF7
//   data_len       : data bytes that follow this status (0..2)
//   keeps_running  : channel-voice status, which establishes running status
module midi_status_decode
  import midi_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_status,
  output logic       is_realtime,
  output logic       is_sysex_start,
  output logic       is_sysex_end,
  output logic [1:0] data_len,
  output logic       keeps_running
);

  assign is_status      = byte_in[7];
  assign is_realtime    = (byte_in[7:3] == 5'b11111);
  assign is_sysex_start = (byte_in == SYSEX_START);
  assign is_sysex_end   = (byte_in == SYSEX_END);
  assign data_len       = midi_data_len(byte_in);
  assign keeps_running  = byte_in[7] && (byte_in[7:4] != 4'hF);

endmodule

// File: rtl/midi_parser.sv
// midi_parser
// Assembles a MIDI byte stream into complete channel-voice / system-common
// messages, with running status, interleaved real-time bytes and SysEx skip.
//   clk, reset       : clock and synchronous active-high reset
//   byte_in/valid    : received byte and its single-cycle strobe
//   msg_valid        : one-cycle strobe, msg_status/data1/data2 hold a message
//   msg_status       : status byte (running status re-supplied)
//   msg_data1/2      : data bytes, 0 when the message has fewer
//   rt_valid/rt_byte : one-cycle strobe and value of a real-time byte
//   err              : sticky, a data byte arrived with no running status
module midi_parser
  import midi_pkg::*;
#(
  parameter bit         OMNI                = 1'b1,
  parameter logic [3:0] CHANNEL             = 4'd0,
  parameter bit         NOTE_ON_ZERO_IS_OFF = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic       err
);

  parser_state_t state_q, state_d;
  logic [7:0] run_status_q, run_status_d;
  logic [6:0] data1_q, data1_d;
  logic       err_q, err_d;
  logic       msg_valid_q, msg_valid_d;
  logic [7:0] msg_status_q, msg_status_d;
  logic [6:0] msg_data1_q, msg_data1_d;
  logic [6:0] msg_data2_q, msg_data2_d;
  logic       rt_valid_q, rt_valid_d;
  logic [7:0] rt_byte_q, rt_byte_d;

  logic       in_is_status;
  logic       in_is_realtime;
  logic       in_is_sysex_start;
  logic       in_is_sysex_end;
  logic [1:0] in_data_len;
  logic       in_keeps_running;

  // Properties of the held status; one-shot system-common statuses are held
  // here too and dropped once their message completes.
  logic [1:0] held_len;
  logic       held_keeps_running;

  logic       emit_req;
  logic [7:0] emit_status;
  logic [6:0] emit_d1;
  logic [6:0] emit_d2;
  logic       emit_pass;
  logic [7:0] emit_status_final;

  midi_status_decode u_decode (
    .byte_in        (byte_in),
    .is_status      (in_is_status),
    .is_realtime    (in_is_realtime),
    .is_sysex_start (in_is_sysex_start),
    .is_sysex_end   (in_is_sysex_end),
    .data_len       (in_data_len),
    .keeps_running  (in_keeps_running)
  );

  assign held_len           = midi_data_len(run_status_q);
  assign held_keeps_running = run_status_q[7] && (run_status_q[7:4] != 4'hF);

  always_comb begin
    state_d           = state_q;
    run_status_d      = run_status_q;
    data1_d           = data1_q;
    err_d             = err_q;
    msg_valid_d       = 1'b0;
    msg_status_d      = msg_status_q;
    msg_data1_d       = msg_data1_q;
    msg_data2_d       = msg_data2_q;
    rt_valid_d        = 1'b0;
    rt_byte_d         = rt_byte_q;
    emit_req          = 1'b0;
    emit_status       = run_status_q;
    emit_d1           = 7'd0;
    emit_d2           = 7'd0;
    emit_pass         = 1'b0;
    emit_status_final = 8'd0;

    if (byte_valid) begin
      if (in_is_realtime) begin
        // Real-time bytes pass straight through without disturbing the
        // message being assembled.
        rt_valid_d = 1'b1;
        rt_byte_d  = byte_in;
      end else if (in_is_status) begin
        if ((state_q == SYSEX) && in_is_sysex_end) begin
          state_d      = NO_STATUS;
          run_status_d = 8'd0;
        end else if (in_keeps_running) begin
          run_status_d = byte_in;
          state_d      = WAIT_D1;
        end else begin
          // System common always cancels running status. This branch also
          // handles a status that aborts an unterminated SysEx.
          run_status_d = 8'd0;
          state_d      = NO_STATUS;
          if (in_is_sysex_start) begin
            state_d = SYSEX;
          end else if (in_data_len != 2'd0) begin
            run_status_d = byte_in;
            state_d      = WAIT_D1;
          end else if (byte_in == TUNE_REQ) begin
            emit_req    = 1'b1;
            emit_status = byte_in;
          end
        end
      end else begin
        case (state_q)
          NO_STATUS: err_d = 1'b1;
          WAIT_D1: begin
            if (held_len == 2'd1) begin
              emit_req = 1'b1;
              emit_d1  = byte_in[6:0];
              if (held_keeps_running) begin
                state_d = WAIT_D1;
              end else begin
                state_d      = NO_STATUS;
                run_status_d = 8'd0;
              end
            end else begin
              data1_d = byte_in[6:0];
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            emit_req = 1'b1;
            emit_d1  = data1_q;
            emit_d2  = byte_in[6:0];
            if (held_keeps_running) begin
              state_d = WAIT_D1;
            end else begin
              state_d      = NO_STATUS;
              run_status_d = 8'd0;
            end
          end
          default: ;
        endcase
      end
    end

    // Channel filtering only affects the strobe and outputs; the FSM above
    // has already advanced as if the message were accepted.
    if (emit_req) begin
      emit_pass = 1'b1;
      if (!OMNI && (emit_status[7:4] != 4'hF) && (emit_status[3:0] != CHANNEL)) begin
        emit_pass = 1'b0;
      end
      emit_status_final = emit_status;
      if (NOTE_ON_ZERO_IS_OFF && (emit_status[7:4] == 4'h9) && (emit_d2 == 7'd0)) begin
        emit_status_final = {4'h8, emit_status[3:0]};
      end
      if (emit_pass) begin
        msg_valid_d  = 1'b1;
        msg_status_d = emit_status_final;
        msg_data1_d  = emit_d1;
        msg_data2_d  = emit_d2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= NO_STATUS;
      run_status_q <= 8'd0;
      data1_q      <= 7'd0;
      err_q        <= 1'b0;
      msg_valid_q  <= 1'b0;
      msg_status_q <= 8'd0;
      msg_data1_q  <= 7'd0;
      msg_data2_q  <= 7'd0;
      rt_valid_q   <= 1'b0;
      rt_byte_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      run_status_q <= run_status_d;
      data1_q      <= data1_d;
      err_q        <= err_d;
      msg_valid_q  <= msg_valid_d;
      msg_status_q <= msg_status_d;
      msg_data1_q  <= msg_data1_d;
      msg_data2_q  <= msg_data2_d;
      rt_valid_q   <= rt_valid_d;
      rt_byte_q    <= rt_byte_d;
    end
  end

  assign msg_valid  = msg_valid_q;
  assign msg_status = msg_status_q;
  assign msg_data1  = msg_data1_q;
  assign msg_data2  = msg_data2_q;
  assign rt_valid   = rt_valid_q;
  assign rt_byte    = rt_byte_q;
  assign err        = err_q;

endmodule

// File: tb/tb_midi_parser.sv
// tb_midi_parser
// Drives one byte stream into two parsers (omni, and channel-2 only) and
// compares every output after every cycle with a queue-based message model.
module tb_midi_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;

  logic       msg_valid  [2];
  logic [7:0] msg_status [2];
  logic [6:0] msg_data1  [2];
  logic [6:0] msg_data2  [2];
  logic       rt_valid   [2];
  logic [7:0] rt_byte    [2];
  logic       err        [2];

  int checks = 0;
  int errors = 0;

  // Model state: held status (0 = none), data bytes collected so far.
  logic [7:0] m_status;
  logic [7:0] m_data[$];
  bit         m_sysex;
  bit         m_err;
  logic       exp_valid  [2];
  logic [7:0] exp_status [2];
  logic [6:0] exp_d1     [2];
  logic [6:0] exp_d2     [2];
  logic       exp_rt;
  logic [7:0] exp_rt_byte;

  midi_parser dut_omni (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .msg_valid(msg_valid[0]), .msg_status(msg_status[0]),
    .msg_data1(msg_data1[0]), .msg_data2(msg_data2[0]),
    .rt_valid(rt_valid[0]), .rt_byte(rt_byte[0]), .err(err[0])
  );

  midi_parser #(.OMNI(1'b0), .CHANNEL(4'd2), .NOTE_ON_ZERO_IS_OFF(1'b1)) dut_ch2 (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .msg_valid(msg_valid[1]), .msg_status(msg_status[1]),
    .msg_data1(msg_data1[1]), .msg_data2(msg_data2[1]),
    .rt_valid(rt_valid[1]), .rt_byte(rt_byte[1]), .err(err[1])
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  // Number of data bytes a message with this status needs.
  function automatic int lenOf(input logic [7:0] s);
    if (s[7:4] == 4'hC || s[7:4] == 4'hD) return 1;
    if (s < 8'hF0) return 2;
    if (s == 8'hF2) return 2;
    if (s == 8'hF1 || s == 8'hF3) return 1;
    return 0;
  endfunction

  // A complete message reaches the output of each configuration unless that
  // configuration's channel filter rejects it.
  function void deliver(input logic [7:0] s, input logic [6:0] d1, input logic [6:0] d2);
    logic [7:0] so;
    for (int k = 0; k < 2; k++) begin
      so = s;
      if (!(k == 1 && s < 8'hF0 && s[3:0] != 4'd2)) begin
        if (so[7:4] == 4'h9 && d2 == 7'd0) so = so - 8'h10;
        exp_valid[k]  = 1'b1;
        exp_status[k] = so;
        exp_d1[k]     = d1;
        exp_d2[k]     = d2;
      end
    end
  endfunction

  function void modelReset();
    m_status = 8'd0;
    m_data.delete();
    m_sysex  = 1'b0;
    m_err    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_valid[k] = 1'b0; exp_status[k] = 8'd0; exp_d1[k] = 7'd0; exp_d2[k] = 7'd0;
    end
    exp_rt      = 1'b0;
    exp_rt_byte = 8'd0;
  endfunction

  function void modelIdle();
    exp_valid[0] = 1'b0;
    exp_valid[1] = 1'b0;
    exp_rt       = 1'b0;
  endfunction

  function void modelByte(input logic [7:0] b);
    int need;
    modelIdle();
    if (b >= 8'hF8) begin
      exp_rt      = 1'b1;
      exp_rt_byte = b;
    end else if (b >= 8'h80) begin
      m_data.delete();
      if (m_sysex && b == 8'hF7) begin
        m_sysex  = 1'b0;
        m_status = 8'd0;
      end else begin
        m_sysex = 1'b0;
        if (b < 8'hF0) m_status = b;
        else begin
          m_status = 8'd0;
          if (b == 8'hF0) m_sysex = 1'b1;
          else if (b == 8'hF1 || b == 8'hF2 || b == 8'hF3) m_status = b;
          else if (b == 8'hF6) deliver(b, 7'd0, 7'd0);
        end
      end
    end else if (!m_sysex) begin
      if (m_status == 8'd0) m_err = 1'b1;
      else begin
        m_data.push_back(b);
        need = lenOf(m_status);
        if (m_data.size() == need) begin
          deliver(m_status, m_data[0][6:0], (need == 2) ? m_data[1][6:0] : 7'd0);
          m_data.delete();
          if (m_status >= 8'hF0) m_status = 8'd0;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  // Compare every output of both parsers with the model.
  task automatic checkOutput(input string ctx);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s dut%0d msg_valid", ctx, k), {7'd0, msg_valid[k]}, {7'd0, exp_valid[k]});
      check($sformatf("%s dut%0d msg_status", ctx, k), msg_status[k], exp_status[k]);
      check($sformatf("%s dut%0d msg_data1", ctx, k), {1'b0, msg_data1[k]}, {1'b0, exp_d1[k]});
      check($sformatf("%s dut%0d msg_data2", ctx, k), {1'b0, msg_data2[k]}, {1'b0, exp_d2[k]});
      check($sformatf("%s dut%0d rt_valid", ctx, k), {7'd0, rt_valid[k]}, {7'd0, exp_rt});
      check($sformatf("%s dut%0d rt_byte", ctx, k), rt_byte[k], exp_rt_byte);
      check($sformatf("%s dut%0d err", ctx, k), {7'd0, err[k]}, {7'd0, m_err});
    end
  endtask

  // One byte per cycle; consecutive calls keep byte_valid high throughout.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    modelByte(b);
    @(posedge clk);
    #1;
    checkOutput($sformatf("byte %02h", b));
  endtask

  task automatic idleCycle();
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
    modelIdle();
    @(posedge clk);
    #1;
    checkOutput("idle");
  endtask

  // Synchronous reset with a live byte on the input, which must be ignored.
  task automatic doReset(input logic [7:0] b);
    @(negedge clk);
    reset      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = b;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("reset");
    @(negedge clk);
    reset      = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic sendSeq(input logic [7:0] seq[$]);
    foreach (seq[i]) applyStimulus(seq[i]);
  endtask

  initial begin
    int r;
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'd0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed: note on");
    sendSeq('{8'h90, 8'h3C, 8'h64});
    idleCycle();
    $display("[TB] directed: running status with velocity 0");
    sendSeq('{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h00});
    $display("[TB] directed: real-time inside a message");
    sendSeq('{8'h90, 8'h3C, 8'hF8, 8'h64});
    $display("[TB] directed: program change running status");
    sendSeq('{8'hC5, 8'h07, 8'h08});
    $display("[TB] directed: system common");
    sendSeq('{8'hF2, 8'h11, 8'h22, 8'h33, 8'hF6, 8'hF3, 8'h05, 8'hF1, 8'h7F});
    doReset(8'h00);
    $display("[TB] directed: SysEx then orphan data");
    sendSeq('{8'hF0, 8'h7E, 8'hFE, 8'h01, 8'hF7, 8'h40});
    doReset(8'h00);
    $display("[TB] directed: SysEx aborted by status");
    sendSeq('{8'hF0, 8'h01, 8'h92, 8'h10, 8'h20, 8'hF4, 8'h30, 8'hF7});
    doReset(8'h00);
    $display("[TB] directed: channel filter");
    sendSeq('{8'h91, 8'h3C, 8'h64, 8'h92, 8'h3C, 8'h64, 8'h92, 8'h3C});
    doReset(8'h64);
    sendSeq('{8'h3C, 8'h64});
    doReset(8'h00);

    $display("[TB] random stream");
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) doReset(8'($urandom));
      else if (r < 8) idleCycle();
      else if (r < 18) applyStimulus(8'h00);
      else if (r < 55) applyStimulus(8'($urandom_range(0, 127)));
      else if (r < 80) applyStimulus(8'($urandom_range(8'h80, 8'hEF)));
      else if (r < 88) applyStimulus(8'($urandom_range(8'hF8, 8'hFF)));
      else applyStimulus(8'($urandom_range(8'hF0, 8'hF7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
